// File: rtl/sysarr_input_fifo_if.sv
// Row-load and lane-pop bundle between the memory subsystem / control unit
// and the systolic-array input skew buffer.
interface sysarr_input_fifo_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic              input_load;
  logic [IW-1:0]     input_row;
  logic [N*DW-1:0]   row_data;
  logic [N-1:0]      in_fifo_shift;
  logic [N*DW-1:0]   lane_out;
  logic [N-1:0]      lane_valid;
  logic [1:0]        slot_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output input_load, input_row, row_data, in_fifo_shift,
    input  lane_out, lane_valid, slot_full, overflow, underflow
  );

  modport slave (
    input  input_load, input_row, row_data, in_fifo_shift,
    output lane_out, lane_valid, slot_full, overflow, underflow
  );
endinterface

// File: rtl/sysarr_input_fifo.sv
// Two-slot (ping-pong) input skew buffer for the systolic array west edge:
// whole rows load in any order, each lane drains its column on its own strobe.
module sysarr_input_fifo #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic               clk,
  input  logic               RST,
  sysarr_input_fifo_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0]   mem [2][N][N];
  logic            wr_slot;
  logic [N-1:0]    row_mask [2];
  logic [1:0]      slot_full_q;
  logic [N-1:0]    rd_slot;
  logic [IW-1:0]   rd_idx [N];
  logic [N*DW-1:0] lane_out_q;
  logic [N-1:0]    lane_valid_q;
  logic            overflow_q;
  logic            underflow_q;

  logic            load_ok;
  logic            load_drop;
  logic [N-1:0]    mask_upd;
  logic            slot_done;
  logic [N-1:0]    pop_ok;
  logic            release_ok;
  logic [1:0]      slot_full_nxt;

  always_comb begin
    load_ok       = bus.input_load & ~slot_full_q[wr_slot];
    load_drop     = bus.input_load &  slot_full_q[wr_slot];
    mask_upd      = row_mask[wr_slot] | (N'(1) << bus.input_row);
    slot_done     = load_ok & (&mask_upd);
    for (int f = 0; f < N; f++) begin
      pop_ok[f] = bus.in_fifo_shift[f] & slot_full_q[rd_slot[f]];
    end
    // Lane N-1 drains last under the staggered windows, so its final pop frees the slot.
    release_ok    = pop_ok[N-1] & (rd_idx[N-1] == IW'(N-1));
    slot_full_nxt = slot_full_q;
    if (release_ok) slot_full_nxt[rd_slot[N-1]] = 1'b0;
    if (slot_done)  slot_full_nxt[wr_slot]      = 1'b1;
  end

  // Control, pointers and registered lane outputs
  always_ff @(posedge clk) begin
    if (RST) begin
      wr_slot      <= 1'b0;
      row_mask[0]  <= '0;
      row_mask[1]  <= '0;
      slot_full_q  <= 2'b00;
      rd_slot      <= '0;
      for (int f = 0; f < N; f++) rd_idx[f] <= '0;
      lane_out_q   <= '0;
      lane_valid_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      slot_full_q <= slot_full_nxt;
      if (load_ok) begin
        if (slot_done) begin
          row_mask[wr_slot] <= '0;
          wr_slot           <= ~wr_slot;
        end else begin
          row_mask[wr_slot] <= mask_upd;
        end
      end
      if (load_drop) overflow_q <= 1'b1;
      for (int f = 0; f < N; f++) begin
        if (pop_ok[f]) begin
          lane_out_q[f*DW +: DW] <= mem[rd_slot[f]][f][rd_idx[f]];
          lane_valid_q[f]        <= 1'b1;
          if (rd_idx[f] == IW'(N-1)) begin
            rd_idx[f]  <= '0;
            rd_slot[f] <= ~rd_slot[f];
          end else begin
            rd_idx[f]  <= rd_idx[f] + IW'(1);
          end
        end else begin
          // Bubble or underflow: zero padding keeps the wavefront skew clean.
          lane_out_q[f*DW +: DW] <= '0;
          lane_valid_q[f]        <= 1'b0;
          if (bus.in_fifo_shift[f]) underflow_q <= 1'b1;
        end
      end
    end
  end

  // Storage: no reset; pops in the same cycle read the pre-edge contents
  always_ff @(posedge clk) begin
    if (load_ok) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_slot][c][bus.input_row] <= bus.row_data[c*DW +: DW];
      end
    end
  end

  assign bus.lane_out   = lane_out_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.slot_full  = slot_full_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule
